// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave register bank: default ID and register map.
package spi_slave_pkg;

    localparam logic [7:0] ID_DEFAULT = 8'hA5;

    localparam logic [7:0] ADDR_ID           = 8'h00;
    localparam logic [7:0] ADDR_CTRL         = 8'h01;
    localparam logic [7:0] ADDR_STATUS       = 8'h02;
    localparam logic [7:0] ADDR_FIFO_LEVEL   = 8'h03;
    localparam logic [7:0] ADDR_FIFO_DATA    = 8'h04;
    localparam logic [7:0] ADDR_IRQ_FLAGS    = 8'h05;
    localparam logic [7:0] ADDR_IRQ_MASK     = 8'h06;
    localparam logic [7:0] ADDR_FIFO_CTRL    = 8'h07;
    localparam logic [3:0] ADDR_SCRATCH_PAGE = 4'h1;

    // Scratch registers occupy 0x10-0x1F.
    function automatic logic is_scratch(input logic [7:0] addr);
        return addr[7:4] == ADDR_SCRATCH_PAGE;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous TX FIFO with push/pop/flush; flush wins over everything else.
module spi_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    // Accept logic and pointer/count next state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        pop_ok   = i_pop && !o_empty && !i_flush;
        push_ok  = i_push && (!o_full || pop_ok) && !i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok) count_d = count_q + CW'(1);
            else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: address decode, control/mask/scratch registers, IRQ flags, TX FIFO.
module spi_reg_bank
    import spi_slave_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  ID_VALUE   = ID_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_bus_addr,
    input  logic [7:0] i_bus_data,
    input  logic       i_bus_wr,
    output logic [7:0] o_bus_data,
    output logic [7:0] o_ctrl,
    input  logic [7:0] i_status,
    input  logic [3:0] i_event,
    output logic [7:0] o_fifo_data,
    output logic       o_fifo_valid,
    input  logic       i_fifo_ready,
    output logic       o_irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    ctrl_q, ctrl_d;
    logic [7:0]    mask_q, mask_d;
    logic [4:0]    flags_q, flags_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    bus_data_q, bus_data_d;
    logic          irq_q, irq_d;
    logic [7:0]    scratch_q [16];
    logic [7:0]    scratch_d [16];

    logic          wr_fifo_data, fifo_flush, fifo_pop, ovf_evt;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign o_bus_data   = bus_data_q;
    assign o_ctrl       = ctrl_q;
    assign o_irq        = irq_q;
    assign o_fifo_valid = !fifo_empty;

    spi_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (wr_fifo_data),
        .i_push_data (i_bus_data),
        .i_pop       (fifo_pop),
        .i_flush     (fifo_flush),
        .o_head      (o_fifo_data),
        .o_count     (fifo_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // Write decode, flag set/clear (set wins), overflow tracking and registered read mux.
    always_comb begin
        wr_fifo_data = i_bus_wr && (i_bus_addr == ADDR_FIFO_DATA);
        fifo_flush   = i_bus_wr && (i_bus_addr == ADDR_FIFO_CTRL) && i_bus_data[0];
        fifo_pop     = o_fifo_valid && i_fifo_ready;
        ovf_evt      = wr_fifo_data && fifo_full && !fifo_pop;

        ctrl_d    = ctrl_q;
        mask_d    = mask_q;
        scratch_d = scratch_q;
        flags_d   = flags_q;

        if (i_bus_wr) begin
            if (i_bus_addr == ADDR_CTRL)      ctrl_d  = i_bus_data;
            if (i_bus_addr == ADDR_IRQ_MASK)  mask_d  = i_bus_data;
            if (i_bus_addr == ADDR_IRQ_FLAGS) flags_d = flags_q & ~i_bus_data[4:0];
            if (is_scratch(i_bus_addr))       scratch_d[i_bus_addr[3:0]] = i_bus_data;
        end
        flags_d = flags_d | {ovf_evt, i_event};

        overflow_d = fifo_flush ? 1'b0 : (overflow_q | ovf_evt);
        irq_d      = |(flags_q & mask_q[4:0]);

        case (i_bus_addr)
            ADDR_ID:         bus_data_d = ID_VALUE;
            ADDR_CTRL:       bus_data_d = ctrl_q;
            ADDR_STATUS:     bus_data_d = i_status;
            ADDR_FIFO_LEVEL: bus_data_d = {overflow_q, 7'(fifo_count)};
            ADDR_IRQ_FLAGS:  bus_data_d = {3'b000, flags_q};
            ADDR_IRQ_MASK:   bus_data_d = mask_q;
            default:         bus_data_d = is_scratch(i_bus_addr) ? scratch_q[i_bus_addr[3:0]] : 8'h00;
        endcase
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl_q     <= '0;
            mask_q     <= '0;
            flags_q    <= '0;
            overflow_q <= 1'b0;
            bus_data_q <= '0;
            irq_q      <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) scratch_q[i] <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            mask_q     <= mask_d;
            flags_q    <= flags_d;
            overflow_q <= overflow_d;
            bus_data_q <= bus_data_d;
            irq_q      <= irq_d;
            scratch_q  <= scratch_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank.
module tb_spi_reg_bank;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_bus_addr;
    logic [7:0] i_bus_data;
    logic       i_bus_wr;
    logic [7:0] o_bus_data;
    logic [7:0] o_ctrl;
    logic [7:0] i_status;
    logic [3:0] i_event;
    logic [7:0] o_fifo_data;
    logic       o_fifo_valid;
    logic       i_fifo_ready;
    logic       o_irq;

    int checks = 0;
    int errors = 0;

    spi_reg_bank #(
        .FIFO_DEPTH (16),
        .ID_VALUE   (8'hA5)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_bus_addr   (i_bus_addr),
        .i_bus_data   (i_bus_data),
        .i_bus_wr     (i_bus_wr),
        .o_bus_data   (o_bus_data),
        .o_ctrl       (o_ctrl),
        .i_status     (i_status),
        .i_event      (i_event),
        .o_fifo_data  (o_fifo_data),
        .o_fifo_valid (o_fifo_valid),
        .i_fifo_ready (i_fifo_ready),
        .o_irq        (o_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        i_bus_addr = addr;
        i_bus_data = data;
        i_bus_wr   = 1'b1;
        tick();
        i_bus_wr   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        i_bus_addr = addr;
        tick();
        data = o_bus_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;

        i_reset      = 1'b1;
        i_bus_addr   = 8'h00;
        i_bus_data   = 8'h00;
        i_bus_wr     = 1'b0;
        i_status     = 8'h5A;
        i_event      = 4'h0;
        i_fifo_ready = 1'b0;
        #12;
        check("rst_bus_data", o_bus_data, 8'h00);
        check("rst_ctrl", o_ctrl, 8'h00);
        check("rst_irq", o_irq, 1'b0);
        check("rst_valid", o_fifo_valid, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
        tick();

        // Basic register access
        bus_write(8'h01, 8'h3C);
        check("ctrl_out", o_ctrl, 8'h3C);
        bus_read(8'h01, rd); check("ctrl_read", rd, 8'h3C);
        bus_read(8'h00, rd); check("id_read", rd, 8'hA5);
        bus_write(8'h00, 8'h12);
        bus_read(8'h00, rd); check("id_ro", rd, 8'hA5);
        bus_read(8'h02, rd); check("status_read", rd, 8'h5A);
        bus_write(8'h08, 8'h55);
        bus_read(8'h08, rd); check("unmapped_read", rd, 8'h00);
        bus_write(8'h1F, 8'h77);
        bus_read(8'h1F, rd); check("scratch_1f", rd, 8'h77);
        bus_write(8'h10, 8'h11);
        bus_read(8'h10, rd); check("scratch_10", rd, 8'h11);
        bus_read(8'h04, rd); check("fifo_data_reads0", rd, 8'h00);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) bus_write(8'h04, 8'(i));
        bus_read(8'h03, rd); check("level_full", rd, 8'h10);
        check("valid_full", o_fifo_valid, 1'b1);
        bus_write(8'h04, 8'h10);
        bus_read(8'h03, rd); check("level_ovf", rd, 8'h90);
        bus_read(8'h05, rd); check("flags_ovf", rd, 8'h10);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), o_fifo_data, 8'(i));
            i_fifo_ready = 1'b1;
            tick();
            i_fifo_ready = 1'b0;
        end
        check("valid_drained", o_fifo_valid, 1'b0);
        bus_read(8'h03, rd); check("level_drained", rd, 8'h80);
        bus_write(8'h07, 8'h01);
        bus_read(8'h03, rd); check("level_flushed", rd, 8'h00);
        bus_write(8'h05, 8'h10);
        bus_read(8'h05, rd); check("flags_w1c", rd, 8'h00);

        // Push into a full FIFO together with a pop
        for (int i = 0; i < 16; i++) bus_write(8'h04, 8'(8'h20 + i));
        i_fifo_ready = 1'b1;
        bus_write(8'h04, 8'hEE);
        i_fifo_ready = 1'b0;
        bus_read(8'h03, rd); check("level_pushpop", rd, 8'h10);
        bus_read(8'h05, rd); check("flags_pushpop", rd, 8'h00);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain2_%0d", i), o_fifo_data, (i == 15) ? 8'hEE : 8'(8'h21 + i));
            i_fifo_ready = 1'b1;
            tick();
            i_fifo_ready = 1'b0;
        end
        bus_read(8'h03, rd); check("level_drained2", rd, 8'h00);

        // IRQ flag set, mask, and set-wins-over-clear
        bus_write(8'h06, 8'h01);
        i_event = 4'h1;
        tick();
        i_event = 4'h0;
        check("irq_not_yet", o_irq, 1'b0);
        tick();
        check("irq_set", o_irq, 1'b1);
        i_event = 4'h1;
        bus_write(8'h05, 8'h01);
        i_event = 4'h0;
        bus_read(8'h05, rd); check("flag_set_wins", rd, 8'h01);
        check("irq_held", o_irq, 1'b1);
        bus_write(8'h05, 8'h01);
        bus_read(8'h05, rd); check("flag_cleared", rd, 8'h00);
        check("irq_cleared", o_irq, 1'b0);
        i_event = 4'h4;
        tick();
        i_event = 4'h0;
        tick();
        bus_read(8'h05, rd); check("flag_masked", rd, 8'h04);
        check("irq_masked", o_irq, 1'b0);
        bus_write(8'h05, 8'h04);

        // Flush with simultaneous pop
        for (int i = 0; i < 5; i++) bus_write(8'h04, 8'(8'h40 + i));
        bus_read(8'h03, rd); check("level_5", rd, 8'h05);
        i_fifo_ready = 1'b1;
        bus_write(8'h07, 8'h01);
        check("valid_after_flush", o_fifo_valid, 1'b0);
        bus_read(8'h03, rd); check("level_after_flush", rd, 8'h00);
        i_fifo_ready = 1'b0;

        // Asynchronous reset mid-operation
        bus_write(8'h01, 8'hFF);
        bus_write(8'h1F, 8'h99);
        for (int i = 0; i < 3; i++) bus_write(8'h04, 8'(8'h60 + i));
        i_event = 4'h1;
        tick();
        i_event = 4'h0;
        tick();
        bus_read(8'h01, rd);
        check("pre_rst_ctrl", o_ctrl, 8'hFF);
        check("pre_rst_irq", o_irq, 1'b1);
        check("pre_rst_bus", rd, 8'hFF);
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_ctrl", o_ctrl, 8'h00);
        check("arst_bus", o_bus_data, 8'h00);
        check("arst_irq", o_irq, 1'b0);
        check("arst_valid", o_fifo_valid, 1'b0);
        #3;
        i_reset = 1'b0;
        tick();
        check("post_rst_irq", o_irq, 1'b0);
        check("post_rst_valid", o_fifo_valid, 1'b0);
        bus_read(8'h1F, rd); check("post_rst_scratch", rd, 8'h00);
        bus_read(8'h05, rd); check("post_rst_flags", rd, 8'h00);
        bus_read(8'h03, rd); check("post_rst_level", rd, 8'h00);
        bus_read(8'h06, rd); check("post_rst_mask", rd, 8'h00);
        check("post_rst_irq2", o_irq, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
